// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
//
// Purpose:
//   Parametrised serial sequence detector. It watches a qualified serial bit
//   stream for a runtime-loadable LEN-bit pattern, with the first received bit
//   in the pattern MSB. Overlapping or non-overlapping detection is selected
//   on every clock edge. A match produces a registered one-cycle pulse on y
//   and advances a saturating match counter.
//
// Parameters:
//   LEN      pattern length in bits (2..32)
//   PATTERN  pattern loaded by reset, MSB is the first bit received
//   CNT_W    width of the match counter
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   sin        serial data bit, sampled only when en=1
//   en         bit-valid qualifier
//   ovl        1 = overlapping detection, 0 = non-overlapping detection
//   pat_ld     load pat_in into the pattern register
//   pat_in     new pattern, MSB first
//   cnt_clr    clear match_cnt (wins over a simultaneous match)
//   y          registered one-cycle match pulse
//   match_cnt  saturating count of matches
// -----------------------------------------------------------------------------
module seq_det_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             en,
  input  logic             ovl,
  input  logic             pat_ld,
  input  logic [LEN-1:0]   pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  // The fill counter only has to reach LEN-1, so clog2(LEN) bits suffice
  // for every legal LEN (2..32).
  localparam int             FILL_W   = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [LEN-1:0]    r_pat;
  logic [LEN-2:0]    r_win;
  logic [FILL_W-1:0] r_fill;
  logic              r_y;
  logic [CNT_W-1:0]  r_cnt;

  logic [LEN-1:0]    w_cand;
  logic              w_match;
  logic              w_hit;

  // The candidate word is the held history followed by the bit arriving now.
  // Its low LEN-1 bits are also the next window contents, which avoids a
  // separate shift expression that would break down for LEN=2.
  assign w_cand  = {r_win, sin};
  assign w_match = en & (r_fill == FILL_MAX) & (w_cand == r_pat);

  // A pattern load ignores the bit on that edge, so it can never count.
  assign w_hit   = w_match & ~pat_ld;

  // All detector state lives in one clocked block; reset, then pattern
  // load, then normal sampling, in that order of priority. The counter
  // clear is independent of the load, so it is handled alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= PATTERN;
      r_win  <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_hit && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (pat_ld) begin
        r_pat  <= pat_in;
        r_win  <= '0;
        r_fill <= '0;
        r_y    <= 1'b0;
      end else if (en) begin
        r_win <= w_cand[LEN-2:0];
        r_y   <= w_match;
        // Non-overlapping mode discards the history that formed a match,
        // so the next detection needs LEN fresh bits.
        if (w_match && !ovl) begin
          r_fill <= '0;
        end else if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + 1'b1;
        end
      end else begin
        r_y <= 1'b0;
      end
    end
  end

  assign y         = r_y;
  assign match_cnt = r_cnt;

endmodule
